// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings, memory-control bit positions and multiplier state type
// for the execute stage and its sequential multiplier.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  localparam int MEM_RD = 1;
  localparam int MEM_WR = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier, one partial product per cycle; low WIDTH bits of the product.
// Build option EX_MUL_EARLY_OUT_EN finishes as soon as the remaining multiplier bits are all zero.
module ex_mul_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output mul_state_t       state_o
);

  // Handshake: start_i is honoured only in IDLE, operands are captured on that edge.
  // busy_o is high in every BUSY cycle; done_o pulses during the final BUSY cycle,
  // when product_o already holds the finished product and the FSM returns to IDLE.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic             last;

  always_comb begin
    term        = mplier[0] ? mcand : '0;
    acc_next    = acc + term;
    mplier_next = mplier >> 1;
`ifdef EX_MUL_EARLY_OUT_EN
    last        = (cnt == LAST_CNT) || (mplier_next == '0);
`else
    last        = (cnt == LAST_CNT);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            mcand  <= a_i;
            mplier <= b_i;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          cnt    <= cnt + CNT_W'(1);
          if (last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o    = (state == BUSY);
  assign done_o    = (state == BUSY) && last;
  assign product_o = acc_next;
  assign state_o   = state;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: single-cycle ALU plus a stalling sequential
// multiplier (ex_mul_seq). EX_MUL_EARLY_OUT_EN shortens multiplies with small multipliers.
module ex_mem_stage
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] val1_i,
  input  logic [WIDTH-1:0] val2_i,
  input  logic [WIDTH-1:0] Simm_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [4:0]       rd_addr_i,
  input  logic [1:0]       Mem_i,
  input  logic             WB_i,
  output logic [WIDTH-1:0] ALU_result_o,
  output logic [WIDTH-1:0] store_data_o,
  output logic [4:0]       rd_addr_o,
  output logic [1:0]       Mem_o,
  output logic             WB_o,
  output logic             stall_o
);

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] product;
  logic             mul_req;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  mul_state_t       mul_state;
  logic [4:0]       rd_saved;

  // A store always computes its address from the S-immediate, whatever ALUCtrl says.
  always_comb begin
    alu_res = '0;
    if (Mem_i[MEM_WR]) begin
      alu_res = val1_i + Simm_i;
    end else begin
      case (ALUCtrl_i)
        ALU_ADD: alu_res = val1_i + val2_i;
        ALU_SUB: alu_res = val1_i - val2_i;
        ALU_AND: alu_res = val1_i & val2_i;
        ALU_OR:  alu_res = val1_i | val2_i;
        default: alu_res = '0;
      endcase
    end
  end

  // A multiply without RegWrite is a bubble and never occupies the multiplier.
  assign mul_req   = (ALUCtrl_i == ALU_MUL) && WB_i;
  assign mul_start = mul_req && (mul_state == IDLE);
  assign stall_o   = mul_start || (mul_busy && !mul_done);

  ex_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .a_i       (val1_i),
    .b_i       (val2_i),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (product),
    .state_o   (mul_state)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ALU_result_o <= '0;
      store_data_o <= '0;
      rd_addr_o    <= '0;
      Mem_o        <= '0;
      WB_o         <= 1'b0;
      rd_saved     <= '0;
    end else if (mul_start || (mul_busy && !mul_done)) begin
      ALU_result_o <= '0;
      store_data_o <= '0;
      rd_addr_o    <= '0;
      Mem_o        <= '0;
      WB_o         <= 1'b0;
      if (mul_start) rd_saved <= rd_addr_i;
    end else if (mul_busy) begin
      ALU_result_o <= product;
      store_data_o <= '0;
      rd_addr_o    <= rd_saved;
      Mem_o        <= '0;
      WB_o         <= 1'b1;
    end else begin
      ALU_result_o <= alu_res;
      store_data_o <= Mem_i[MEM_WR] ? val2_i : '0;
      rd_addr_o    <= rd_addr_i;
      Mem_o        <= Mem_i;
      WB_o         <= WB_i;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: ALU vector table, then multiply, back-to-back and reset
// sequences. Stall-count expectations follow EX_MUL_EARLY_OUT_EN when it is defined.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] val1, val2, simm;
  logic [3:0]  ctrl;
  logic [4:0]  rd_addr;
  logic [1:0]  mem;
  logic        wb;
  logic [31:0] ALU_result_o, store_data_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  Mem_o;
  logic        WB_o, stall_o;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.WIDTH(32), .CNT_W(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .val1_i       (val1),
    .val2_i       (val2),
    .Simm_i       (simm),
    .ALUCtrl_i    (ctrl),
    .rd_addr_i    (rd_addr),
    .Mem_i        (mem),
    .WB_i         (wb),
    .ALU_result_o (ALU_result_o),
    .store_data_o (store_data_o),
    .rd_addr_o    (rd_addr_o),
    .Mem_o        (Mem_o),
    .WB_o         (WB_o),
    .stall_o      (stall_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] v1, v2, simm;
    logic [4:0]  rd;
    logic [1:0]  mem;
    logic        wb;
    logic [31:0] e_res, e_sd;
    logic [4:0]  e_rd;
    logic [1:0]  e_mem;
    logic        e_wb;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_nop();
    val1 = '0; val2 = '0; simm = '0; ctrl = 4'b0000;
    rd_addr = '0; mem = 2'b00; wb = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " result"}, ALU_result_o, 32'h0);
    check({tag, " store_data"}, store_data_o, 32'h0);
    check({tag, " rd"}, 32'(rd_addr_o), 32'h0);
    check({tag, " mem"}, 32'(Mem_o), 32'h0);
    check({tag, " wb"}, 32'(WB_o), 32'h0);
  endtask

  function automatic int exp_stalls(input logic [31:0] b);
    int n;
`ifdef EX_MUL_EARLY_OUT_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`else
    n = 32;
`endif
    return n;
  endfunction

  // Present a multiply, count stall cycles (bounded), verify bubbles and the writeback.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res);
    int   stalls;
    logic bad;
    val1 = a; val2 = b; simm = '0; ctrl = 4'b1111; rd_addr = rd; mem = 2'b00; wb = 1'b1;
    #1;
    stalls = 0;
    bad    = 1'b0;
    while (stall_o === 1'b1 && stalls < 100) begin
      stalls++;
      @(posedge clk); #1;
      if (WB_o !== 1'b0 || Mem_o !== 2'b00 || rd_addr_o !== 5'd0) bad = 1'b1;
    end
    check({name, " stall cycles"}, 32'(stalls), 32'(exp_stalls(b)));
    check({name, " bubble while stalled"}, 32'(bad), 32'h0);
    @(posedge clk); #1;
    check({name, " result"}, ALU_result_o, exp_res);
    check({name, " wb"}, 32'(WB_o), 32'h1);
    check({name, " rd"}, 32'(rd_addr_o), 32'(rd));
    check({name, " mem"}, 32'(Mem_o), 32'h0);
    drive_nop();
  endtask

  initial begin
    vecs[0] = '{"add",       4'b0010, 32'd5,      32'd7,      32'h0,   5'd3, 2'b00, 1'b1, 32'd12,        32'h0,  5'd3, 2'b00, 1'b1};
    vecs[1] = '{"sub wrap",  4'b0110, 32'd0,      32'd1,      32'h0,   5'd4, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'h0,  5'd4, 2'b00, 1'b1};
    vecs[2] = '{"and",       4'b0000, 32'hF0F0,   32'h0FF0,   32'h0,   5'd5, 2'b00, 1'b1, 32'h00F0,      32'h0,  5'd5, 2'b00, 1'b1};
    vecs[3] = '{"or",        4'b0001, 32'hF0F0,   32'h0FF0,   32'h0,   5'd6, 2'b00, 1'b1, 32'hFFF0,      32'h0,  5'd6, 2'b00, 1'b1};
    vecs[4] = '{"store",     4'b0010, 32'h100,    32'hAB,     32'h8,   5'd0, 2'b01, 1'b0, 32'h108,       32'hAB, 5'd0, 2'b01, 1'b0};
    vecs[5] = '{"store sub", 4'b0110, 32'h20,     32'h55,     32'h4,   5'd0, 2'b01, 1'b0, 32'h24,        32'h55, 5'd0, 2'b01, 1'b0};
    vecs[6] = '{"load",      4'b0010, 32'h200,    32'h10,     32'h99,  5'd7, 2'b10, 1'b1, 32'h210,       32'h0,  5'd7, 2'b10, 1'b1};
    vecs[7] = '{"unlisted",  4'b0101, 32'd3,      32'd4,      32'h0,   5'd8, 2'b00, 1'b1, 32'h0,         32'h0,  5'd8, 2'b00, 1'b1};
    vecs[8] = '{"mul bubble",4'b1111, 32'd6,      32'd7,      32'h0,   5'd9, 2'b00, 1'b0, 32'h0,         32'h0,  5'd9, 2'b00, 1'b0};
    vecs[9] = '{"sub",       4'b0110, 32'd10,     32'd3,      32'h0,   5'd1, 2'b00, 1'b1, 32'd7,         32'h0,  5'd1, 2'b00, 1'b1};

    rst = 1'b1;
    drive_nop();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset stall", 32'(stall_o), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      val1 = vecs[i].v1; val2 = vecs[i].v2; simm = vecs[i].simm; ctrl = vecs[i].ctrl;
      rd_addr = vecs[i].rd; mem = vecs[i].mem; wb = vecs[i].wb;
      #1;
      check({vecs[i].name, " stall"}, 32'(stall_o), 32'h0);
      @(posedge clk); #1;
      check({vecs[i].name, " result"}, ALU_result_o, vecs[i].e_res);
      check({vecs[i].name, " store_data"}, store_data_o, vecs[i].e_sd);
      check({vecs[i].name, " rd"}, 32'(rd_addr_o), 32'(vecs[i].e_rd));
      check({vecs[i].name, " mem"}, 32'(Mem_o), 32'(vecs[i].e_mem));
      check({vecs[i].name, " wb"}, 32'(WB_o), 32'(vecs[i].e_wb));
    end
    drive_nop();
    @(posedge clk); #1;

    run_mul("mul 6x7", 32'd6, 32'd7, 5'd9, 32'd42);
    run_mul("mul overflow", 32'h8000_0000, 32'd2, 5'd10, 32'h0);
    run_mul("mul by 1", 32'h1234, 32'd1, 5'd11, 32'h1234);
    run_mul("mul by 8", 32'd5, 32'd8, 5'd12, 32'd40);
    run_mul("mul by 0", 32'hDEAD, 32'd0, 5'd13, 32'h0);
    run_mul("mul all ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'h1);
    // back-to-back: the second multiply is presented the cycle after the first completes
    run_mul("b2b first", 32'd3, 32'd4, 5'd15, 32'd12);
    run_mul("b2b second", 32'h0001_0001, 32'h0001_0001, 5'd16, 32'h0002_0001);
    @(posedge clk); #1;
    check("after mul wb", 32'(WB_o), 32'h0);

    // reset during BUSY cycle 10 aborts the multiply with no writeback
    val1 = 32'd6; val2 = 32'h8000_0007; ctrl = 4'b1111; rd_addr = 5'd9; mem = 2'b00; wb = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("pre-reset stall", 32'(stall_o), 32'h1);
    rst = 1'b1;
    drive_nop();
    @(posedge clk); #1;
    check_all_zero("mid-mul reset");
    check("mid-mul reset stall", 32'(stall_o), 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no late writeback", 32'(WB_o), 32'h0);
    check("no late rd", 32'(rd_addr_o), 32'h0);
    run_mul("mul after reset", 32'd6, 32'd7, 5'd9, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
